// File: rtl/uart_pkg.sv
// Shared types and constants for the UART core.
package uart_pkg;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

  // RX_WAIT holds off after a bad stop bit until the line returns high.
  typedef enum logic [2:0] {
    RX_IDLE  = 3'd0,
    RX_START = 3'd1,
    RX_DATA  = 3'd2,
    RX_STOP  = 3'd3,
    RX_WAIT  = 3'd4
  } rx_state_e;

  localparam int unsigned StatusW      = 8;
  localparam int unsigned StTxEmpty    = 0;
  localparam int unsigned StTxFull     = 1;
  localparam int unsigned StRxEmpty    = 2;
  localparam int unsigned StRxFull     = 3;
  localparam int unsigned StRxError    = 4;
  localparam int unsigned StTxBusy     = 5;
  localparam int unsigned StRxBusy     = 6;
  localparam int unsigned StRxOverflow = 7;

  localparam int unsigned CtrlClrErr   = 0;
  localparam int unsigned CtrlFlush    = 1;

endpackage

// File: rtl/uart_fifo.sv
// Synchronous show-ahead FIFO with registered full/empty flags.
module uart_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             flush,
  input  logic             push,
  input  logic [Width-1:0] wdata,
  input  logic             pop,
  output logic [Width-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem [Depth];
  logic [PtrW-1:0]  wr_ptr_q;
  logic [PtrW-1:0]  rd_ptr_q;
  logic [CntW-1:0]  cnt_q;
  logic [CntW-1:0]  cnt_d;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  // Head entry is visible without a read strobe; forced to zero when empty.
  assign rdata = empty ? '0 : mem[rd_ptr_q];

  // Next occupancy; simultaneous push and pop leave it unchanged.
  always_comb begin
    cnt_d = cnt_q;
    if (flush) begin
      cnt_d = '0;
    end else if (do_push && !do_pop) begin
      cnt_d = cnt_q + CntW'(1);
    end else if (!do_push && do_pop) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  // Pointers, count and flags.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
    end else begin
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
        if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      cnt_q <= cnt_d;
      full  <= (cnt_d == CntW'(Depth));
      empty <= (cnt_d == '0);
    end
  end

  // Storage array, no reset needed.
  always_ff @(posedge i_clk) begin
    if (do_push) mem[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/uart_core.sv
// Full-duplex 8N1 UART with TX/RX FIFOs, RTS/CTS and sticky error flags.
module uart_core
  import uart_pkg::*;
#(
  parameter int unsigned DataLength      = 8,
  parameter int unsigned FifoDepth       = 8,
  parameter int unsigned OverSample      = 8,
  parameter int unsigned BaudRate        = 115200,
  parameter int unsigned SystemClockFreq = 133_000_000,
  parameter int unsigned FlowControl     = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [1:0]            i_ctrl,
  output logic [StatusW-1:0]    o_status,
  input  logic [DataLength-1:0] i_tx_data,
  input  logic                  i_tx_req,
  output logic                  o_tx_rdy,
  output logic [DataLength-1:0] o_rx_data,
  input  logic                  i_rx_req,
  output logic                  o_rx_rdy,
  output logic                  o_rx_error,
  input  logic                  i_rx,
  output logic                  o_tx,
  input  logic                  i_cts,
  output logic                  o_rts
);

  localparam int unsigned TickDiv = SystemClockFreq / (BaudRate * OverSample);
  localparam int unsigned TickW   = (TickDiv > 1) ? $clog2(TickDiv) : 1;
  localparam int unsigned OsW     = $clog2(OverSample);
  localparam int unsigned BitW    = (DataLength > 1) ? $clog2(DataLength) : 1;

  logic [TickW-1:0]      tick_cnt_q;
  logic                  tick;
  logic [1:0]            rx_sync_q;
  logic [1:0]            cts_sync_q;
  logic                  rx_s;
  logic                  cts_ok;
  logic                  flush;
  logic                  clr_err;

  logic                  tx_full, tx_empty, tx_pop;
  logic [DataLength-1:0] tx_fifo_data;
  logic                  rx_full, rx_empty, rx_push, rx_ferr;

  tx_state_e             tx_state_q, tx_state_d;
  logic [OsW-1:0]        tx_tcnt_q, tx_tcnt_d;
  logic [BitW-1:0]       tx_bcnt_q, tx_bcnt_d;
  logic [DataLength-1:0] tx_shift_q, tx_shift_d;
  logic                  tx_q, tx_d;
  logic                  tx_bit_end;

  rx_state_e             rx_state_q, rx_state_d;
  logic [OsW-1:0]        rx_tcnt_q, rx_tcnt_d;
  logic [BitW-1:0]       rx_bcnt_q, rx_bcnt_d;
  logic [DataLength-1:0] rx_shift_q, rx_shift_d;
  logic                  rx_bit_end;
  logic                  rx_err_q;
  logic                  rx_ovf_q;
  logic [StatusW-1:0]    status_c;

  assign flush   = i_ctrl[CtrlFlush];
  assign clr_err = i_ctrl[CtrlClrErr];
  assign tick    = (tick_cnt_q == TickW'(TickDiv - 1));
  assign rx_s    = rx_sync_q[1];
  assign cts_ok  = (FlowControl == 0) || cts_sync_q[1];

  // Free-running oversample tick divider.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)     tick_cnt_q <= '0;
    else if (tick) tick_cnt_q <= '0;
    else           tick_cnt_q <= tick_cnt_q + TickW'(1);
  end

  // Two-stage synchronizers; RX idles high, CTS holds off until seen.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rx_sync_q  <= 2'b11;
      cts_sync_q <= 2'b00;
    end else begin
      rx_sync_q  <= {rx_sync_q[0], i_rx};
      cts_sync_q <= {cts_sync_q[0], i_cts};
    end
  end

  uart_fifo #(.Width(DataLength), .Depth(FifoDepth)) u_tx_fifo (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .flush (flush),
    .push  (i_tx_req),
    .wdata (i_tx_data),
    .pop   (tx_pop),
    .rdata (tx_fifo_data),
    .full  (tx_full),
    .empty (tx_empty)
  );

  uart_fifo #(.Width(DataLength), .Depth(FifoDepth)) u_rx_fifo (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .flush (flush),
    .push  (rx_push),
    .wdata (rx_shift_q),
    .pop   (i_rx_req),
    .rdata (o_rx_data),
    .full  (rx_full),
    .empty (rx_empty)
  );

  // TX state and datapath registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      tx_state_q <= TX_IDLE;
      tx_tcnt_q  <= '0;
      tx_bcnt_q  <= '0;
      tx_shift_q <= '0;
      tx_q       <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_tcnt_q  <= tx_tcnt_d;
      tx_bcnt_q  <= tx_bcnt_d;
      tx_shift_q <= tx_shift_d;
      tx_q       <= tx_d;
    end
  end

  assign tx_bit_end = tick && (tx_tcnt_q == OsW'(OverSample - 1));

  // TX next state: frames start on a tick so every bit is exactly OverSample ticks.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_tcnt_d  = tx_tcnt_q;
    tx_bcnt_d  = tx_bcnt_q;
    tx_shift_d = tx_shift_q;
    tx_d       = tx_q;
    tx_pop     = 1'b0;
    if (tick) tx_tcnt_d = tx_bit_end ? '0 : tx_tcnt_q + OsW'(1);
    unique case (tx_state_q)
      TX_IDLE: begin
        tx_d      = 1'b1;
        tx_tcnt_d = '0;
        if (tick && !tx_empty && cts_ok) begin
          tx_pop     = 1'b1;
          tx_shift_d = tx_fifo_data;
          tx_state_d = TX_START;
          tx_d       = 1'b0;
        end
      end
      TX_START: begin
        if (tx_bit_end) begin
          tx_state_d = TX_DATA;
          tx_bcnt_d  = '0;
          tx_d       = tx_shift_q[0];
        end
      end
      TX_DATA: begin
        if (tx_bit_end) begin
          if (tx_bcnt_q == BitW'(DataLength - 1)) begin
            tx_state_d = TX_STOP;
            tx_d       = 1'b1;
          end else begin
            tx_bcnt_d  = tx_bcnt_q + BitW'(1);
            tx_shift_d = tx_shift_q >> 1;
            tx_d       = tx_shift_q[1];
          end
        end
      end
      TX_STOP: begin
        if (tx_bit_end) begin
          if (!tx_empty && cts_ok) begin
            tx_pop     = 1'b1;
            tx_shift_d = tx_fifo_data;
            tx_state_d = TX_START;
            tx_d       = 1'b0;
          end else begin
            tx_state_d = TX_IDLE;
            tx_d       = 1'b1;
          end
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  // RX state and datapath registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rx_state_q <= RX_IDLE;
      rx_tcnt_q  <= '0;
      rx_bcnt_q  <= '0;
      rx_shift_q <= '0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_tcnt_q  <= rx_tcnt_d;
      rx_bcnt_q  <= rx_bcnt_d;
      rx_shift_q <= rx_shift_d;
    end
  end

  assign rx_bit_end = tick && (rx_tcnt_q == OsW'(OverSample - 1));

  // RX next state: recheck start at half a bit, then sample once per bit mid-cell.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_tcnt_d  = rx_tcnt_q;
    rx_bcnt_d  = rx_bcnt_q;
    rx_shift_d = rx_shift_q;
    rx_push    = 1'b0;
    rx_ferr    = 1'b0;
    if (tick) rx_tcnt_d = rx_tcnt_q + OsW'(1);
    unique case (rx_state_q)
      RX_IDLE: begin
        rx_tcnt_d = '0;
        if (!rx_s) rx_state_d = RX_START;
      end
      RX_START: begin
        if (tick && (rx_tcnt_q == OsW'(OverSample / 2 - 1))) begin
          rx_tcnt_d  = '0;
          rx_bcnt_d  = '0;
          rx_state_d = rx_s ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_bit_end) begin
          rx_tcnt_d  = '0;
          rx_shift_d = {rx_s, rx_shift_q[DataLength-1:1]};
          if (rx_bcnt_q == BitW'(DataLength - 1)) rx_state_d = RX_STOP;
          else                                    rx_bcnt_d  = rx_bcnt_q + BitW'(1);
        end
      end
      RX_STOP: begin
        if (rx_bit_end) begin
          rx_tcnt_d = '0;
          if (rx_s) begin
            rx_push    = 1'b1;
            rx_state_d = RX_IDLE;
          end else begin
            rx_ferr    = 1'b1;
            rx_state_d = RX_WAIT;
          end
        end
      end
      RX_WAIT: begin
        rx_tcnt_d = '0;
        if (rx_s) rx_state_d = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // Sticky framing-error and overflow flags; a new event wins over a clear.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rx_err_q <= 1'b0;
      rx_ovf_q <= 1'b0;
    end else begin
      if (rx_ferr)      rx_err_q <= 1'b1;
      else if (clr_err) rx_err_q <= 1'b0;
      if (rx_push && rx_full) rx_ovf_q <= 1'b1;
      else if (clr_err)       rx_ovf_q <= 1'b0;
    end
  end

  // Status word assembled from registered flags.
  always_comb begin
    status_c               = '0;
    status_c[StTxEmpty]    = tx_empty;
    status_c[StTxFull]     = tx_full;
    status_c[StRxEmpty]    = rx_empty;
    status_c[StRxFull]     = rx_full;
    status_c[StRxError]    = rx_err_q;
    status_c[StTxBusy]     = (tx_state_q != TX_IDLE);
    status_c[StRxBusy]     = (rx_state_q != RX_IDLE);
    status_c[StRxOverflow] = rx_ovf_q;
  end

  assign o_status   = status_c;
  assign o_tx       = tx_q;
  assign o_tx_rdy   = !tx_full;
  assign o_rx_rdy   = !rx_empty;
  assign o_rx_error = rx_err_q;
  assign o_rts      = (FlowControl != 0) ? !rx_full : 1'b1;

endmodule

// File: tb/tb_uart_core.sv
// Directed self-checking bench for uart_core (8 clocks per tick, 64 clocks per bit).
module tb_uart_core;

  localparam int unsigned BitCyc   = 64;
  localparam int unsigned HalfBit  = 32;
  localparam int unsigned WaitBudg = 3000;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic [1:0] i_ctrl;
  logic [7:0] o_status;
  logic [7:0] i_tx_data;
  logic       i_tx_req;
  logic       o_tx_rdy;
  logic [7:0] o_rx_data;
  logic       i_rx_req;
  logic       o_rx_rdy;
  logic       o_rx_error;
  logic       i_rx;
  logic       o_tx;
  logic       i_cts;
  logic       o_rts;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] tx_tab  [8] = '{8'hA5, 8'h3C, 8'h00, 8'hFF, 8'h81, 8'h7E, 8'h96, 8'h69};
  logic [7:0] rx_tab  [8] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
  logic [7:0] ovf_tab [9] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99};

  uart_core #(
    .DataLength(8), .FifoDepth(8), .OverSample(8),
    .BaudRate(115200), .SystemClockFreq(7_372_800), .FlowControl(1)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_ctrl(i_ctrl), .o_status(o_status),
    .i_tx_data(i_tx_data), .i_tx_req(i_tx_req), .o_tx_rdy(o_tx_rdy),
    .o_rx_data(o_rx_data), .i_rx_req(i_rx_req), .o_rx_rdy(o_rx_rdy),
    .o_rx_error(o_rx_error), .i_rx(i_rx), .o_tx(o_tx),
    .i_cts(i_cts), .o_rts(o_rts)
  );

  always #5 i_clk = ~i_clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_tx(input logic [7:0] b);
    @(negedge i_clk);
    check_val("tx_rdy_before_write", 32'(o_tx_rdy), 32'd1);
    i_tx_data = b;
    i_tx_req  = 1'b1;
    @(negedge i_clk);
    i_tx_req  = 1'b0;
  endtask

  task automatic pop_rx(input logic [7:0] exp);
    @(negedge i_clk);
    check_val("rx_rdy_before_pop", 32'(o_rx_rdy), 32'd1);
    check_val("rx_data", 32'(o_rx_data), 32'(exp));
    i_rx_req = 1'b1;
    @(negedge i_clk);
    i_rx_req = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    @(negedge i_clk);
    i_rx = 1'b0;
    repeat (BitCyc) @(negedge i_clk);
    for (int k = 0; k < 8; k++) begin
      i_rx = b[k];
      repeat (BitCyc) @(negedge i_clk);
    end
    i_rx = stop;
    repeat (BitCyc) @(negedge i_clk);
    i_rx = 1'b1;
  endtask

  // Wait for a start bit on o_tx, then sample every cell at mid-bit.
  task automatic tx_capture(input logic [7:0] exp, input bit chk_len);
    int unsigned n;
    logic        got;
    logic [7:0]  b;
    n   = 0;
    got = 1'b0;
    b   = '0;
    while (n < WaitBudg && !got) begin
      @(negedge i_clk);
      if (o_tx === 1'b0) got = 1'b1;
      n++;
    end
    if (!got) begin
      check_val("tx_start_timeout", 32'd0, 32'd1);
    end else begin
      for (int c = 1; c <= HalfBit + BitCyc * 9; c++) begin
        @(negedge i_clk);
        if (c == HalfBit) check_val("tx_start_bit", 32'(o_tx), 32'd0);
        if (chk_len && c == BitCyc - 1) check_val("tx_start_len_end", 32'(o_tx), 32'd0);
        if (chk_len && c == BitCyc) check_val("tx_bit0_begin", 32'(o_tx), 32'(exp[0]));
        if (c > HalfBit && ((c - HalfBit) % BitCyc) == 0 && c < HalfBit + BitCyc * 9)
          b[(c - HalfBit) / BitCyc - 1] = o_tx;
        if (c == HalfBit + BitCyc * 9) check_val("tx_stop_bit", 32'(o_tx), 32'd1);
      end
      check_val("tx_byte", 32'(b), 32'(exp));
    end
  endtask

  initial begin
    int lows;
    i_rst = 1'b1; i_ctrl = 2'b00; i_tx_data = '0; i_tx_req = 1'b0;
    i_rx_req = 1'b0; i_rx = 1'b1; i_cts = 1'b1;
    repeat (3) @(negedge i_clk);
    i_rst = 1'b0;
    @(negedge i_clk);
    check_val("rst_tx", 32'(o_tx), 32'd1);
    check_val("rst_tx_rdy", 32'(o_tx_rdy), 32'd1);
    check_val("rst_rx_rdy", 32'(o_rx_rdy), 32'd0);
    check_val("rst_rx_error", 32'(o_rx_error), 32'd0);
    check_val("rst_rx_data", 32'(o_rx_data), 32'd0);
    check_val("rst_rts", 32'(o_rts), 32'd1);
    check_val("rst_status", 32'(o_status), 32'h05);

    // Full duplex: 8 frames out while 8 frames come in.
    fork
      begin for (int i = 0; i < 8; i++) push_tx(tx_tab[i]); end
      begin for (int i = 0; i < 8; i++) tx_capture(tx_tab[i], i == 0); end
      begin for (int i = 0; i < 8; i++) send_frame(rx_tab[i], 1'b1); end
    join
    repeat (100) @(negedge i_clk);
    check_val("duplex_status_rx_full", 32'(o_status), 32'h09);
    check_val("duplex_rts_full", 32'(o_rts), 32'd0);
    for (int i = 0; i < 8; i++) pop_rx(rx_tab[i]);
    @(negedge i_clk);
    check_val("duplex_rx_drained", 32'(o_rx_rdy), 32'd0);
    check_val("duplex_no_error", 32'(o_rx_error), 32'd0);

    // Framing error: byte discarded, flag sticky until reset.
    send_frame(8'h3C, 1'b0);
    repeat (10) @(negedge i_clk);
    check_val("ferr_flag", 32'(o_rx_error), 32'd1);
    check_val("ferr_status_bit", 32'(o_status[4]), 32'd1);
    check_val("ferr_no_byte", 32'(o_rx_rdy), 32'd0);
    i_rst = 1'b1;
    repeat (2) @(negedge i_clk);
    i_rst = 1'b0;
    @(negedge i_clk);
    check_val("ferr_cleared_by_reset", 32'(o_rx_error), 32'd0);
    check_val("ferr_status_after_reset", 32'(o_status), 32'h05);
    send_frame(8'h5A, 1'b1);
    repeat (10) @(negedge i_clk);
    pop_rx(8'h5A);

    // Short low glitch must not start a frame.
    @(negedge i_clk);
    i_rx = 1'b0;
    repeat (20) @(negedge i_clk);
    i_rx = 1'b1;
    repeat (10 * BitCyc) @(negedge i_clk);
    check_val("glitch_no_byte", 32'(o_rx_rdy), 32'd0);
    check_val("glitch_status", 32'(o_status), 32'h05);
    send_frame(8'hC3, 1'b1);
    repeat (10) @(negedge i_clk);
    pop_rx(8'hC3);

    // CTS low holds the transmitter in idle.
    i_cts = 1'b0;
    push_tx(8'h81);
    push_tx(8'h7E);
    lows = 0;
    for (int c = 0; c < 3 * 10 * BitCyc; c++) begin
      @(negedge i_clk);
      if (o_tx !== 1'b1) lows++;
    end
    check_val("cts_hold_line_idle", 32'(lows), 32'd0);
    check_val("cts_hold_tx_not_empty", 32'(o_status[0]), 32'd0);
    check_val("cts_hold_tx_not_busy", 32'(o_status[5]), 32'd0);
    i_cts = 1'b1;
    tx_capture(8'h81, 1'b0);
    tx_capture(8'h7E, 1'b0);

    // Overflow: RTS drops at full, ninth byte dropped.
    for (int i = 0; i < 8; i++) send_frame(ovf_tab[i], 1'b1);
    repeat (10) @(negedge i_clk);
    check_val("ovf_rts_low", 32'(o_rts), 32'd0);
    check_val("ovf_rx_full", 32'(o_status[3]), 32'd1);
    check_val("ovf_flag_not_yet", 32'(o_status[7]), 32'd0);
    send_frame(ovf_tab[8], 1'b1);
    repeat (10) @(negedge i_clk);
    check_val("ovf_flag_set", 32'(o_status[7]), 32'd1);
    check_val("ovf_no_ferr", 32'(o_rx_error), 32'd0);
    for (int i = 0; i < 8; i++) pop_rx(ovf_tab[i]);
    @(negedge i_clk);
    check_val("ovf_drained", 32'(o_rx_rdy), 32'd0);
    check_val("ovf_rts_high", 32'(o_rts), 32'd1);
    check_val("ovf_flag_sticky", 32'(o_status[7]), 32'd1);
    i_ctrl = 2'b01;
    @(negedge i_clk);
    i_ctrl = 2'b00;
    check_val("ovf_flag_cleared", 32'(o_status[7]), 32'd0);

    // Flush discards pending TX bytes.
    i_cts = 1'b0;
    push_tx(8'hAA);
    push_tx(8'h55);
    check_val("flush_tx_pending", 32'(o_status[0]), 32'd0);
    i_ctrl = 2'b10;
    @(negedge i_clk);
    i_ctrl = 2'b00;
    check_val("flush_tx_empty", 32'(o_status[0]), 32'd1);
    check_val("flush_tx_rdy", 32'(o_tx_rdy), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
